// File: rtl/clk_div_pkg.sv
// Shared constants and FSM state encoding for the clk_div_ctrl block.
package clk_div_pkg;

  localparam int unsigned CntWDefault    = 16;
  localparam int unsigned DefHalfDefault = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StPend = 2'd2;

endpackage

// File: rtl/clk_div_counter.sv
// Half-period counter: terminal-count detect, div_out toggle and edge ticks.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] half,
  input  logic             run,
  input  logic             clear,
  output logic             term,
  output logic             falling,
  output logic             div_out,
  output logic             tick_rise,
  output logic             tick_fall
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign term      = run && (cnt_q == half - CNT_W'(1));
  assign falling   = term && div_q;
  assign div_out   = div_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // A stop during the low phase truncates it silently, even on a boundary.
    if (clear || !run) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      div_d  = !div_q;
      rise_d = !div_q;
      fall_d = div_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: FSM, config handshake and pending ratio.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned DEF_HALF = DefHalfDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             active
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q;

  logic accept, cfg_ok, cfg_bad;
  logic running, stop_now, clear;
  logic term, falling;

  assign cfg_ready = (state_q != StPend);
  assign active    = (state_q != StIdle);
  assign cfg_err   = err_q;

  assign accept  = cfg_valid && cfg_ready;
  assign cfg_ok  = accept && (cfg_half != '0);
  assign cfg_bad = accept && (cfg_half == '0);

  assign running = (state_q != StIdle);
  // High phase always runs to its falling boundary; low phase stops at once.
  assign stop_now = running && !en && (!div_out || term);
  assign clear    = running && !en && !div_out;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    pend_d  = pend_q;
    case (state_q)
      StIdle: begin
        if (cfg_ok) half_d = cfg_half;
        if (en) state_d = StRun;
      end
      StRun, StPend: begin
        if (stop_now) begin
          state_d = StIdle;
          if (state_q == StPend) half_d = pend_q;
          else if (cfg_ok)       half_d = cfg_half;
        end else if (state_q == StPend) begin
          if (falling) begin
            half_d  = pend_q;
            state_d = StRun;
          end
        end else if (cfg_ok) begin
          pend_d  = cfg_half;
          state_d = StPend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      half_q  <= CNT_W'(DEF_HALF);
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      err_q   <= cfg_bad;
    end
  end

  clk_div_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .half     (half_q),
    .run      (running),
    .clear    (clear),
    .term     (term),
    .falling  (falling),
    .div_out  (div_out),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios then random traffic vs. a phase-position model.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic        cfg_err;
  logic        div_out;
  logic        tick_rise;
  logic        tick_fall;
  logic        active;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W   (16),
    .DEF_HALF(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .div_out  (div_out),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .active   (active)
  );

  // Model: position inside the period, 0..half-1 low, half..2*half-1 high.
  bit m_run, m_pend, m_rise, m_fall, m_err;
  int m_pos, m_half, m_pendv;
  int nchk  = 0;
  int npass = 0;

  task automatic model_edge(input logic e, input logic cv, input int ch, input logic r);
    bit acc, good, high, last;
    if (!r) begin
      m_run = 0; m_pend = 0; m_pos = 0; m_half = 2; m_pendv = 0;
      m_rise = 0; m_fall = 0; m_err = 0;
      return;
    end
    acc    = cv && !m_pend;
    good   = acc && (ch != 0);
    m_err  = acc && (ch == 0);
    m_rise = 0;
    m_fall = 0;
    if (!m_run) begin
      m_pos = 0;
      if (good) m_half = ch;
      if (e) m_run = 1;
    end else begin
      high = (m_pos >= m_half);
      last = (m_pos == 2 * m_half - 1);
      if (!e && !high) begin
        m_run = 0;
        m_pos = 0;
        if (m_pend) m_half = m_pendv;
        else if (good) m_half = ch;
        m_pend = 0;
      end else begin
        m_rise = (m_pos + 1 == m_half);
        m_fall = last;
        m_pos  = last ? 0 : m_pos + 1;
        if (last && !e) begin
          m_run = 0;
          if (m_pend) m_half = m_pendv;
          else if (good) m_half = ch;
          m_pend = 0;
        end else if (last && m_pend) begin
          m_half = m_pendv;
          m_pend = 0;
        end else if (good) begin
          m_pend  = 1;
          m_pendv = ch;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
  endtask

  task automatic cyc(input logic e, input logic cv, input int ch, input logic r);
    en        = e;
    cfg_valid = cv;
    cfg_half  = 16'(ch);
    rst       = r;
    @(posedge clk);
    model_edge(e, cv, ch, r);
    #1;
    chk("div_out",   div_out,   m_run && (m_pos >= m_half));
    chk("tick_rise", tick_rise, m_rise);
    chk("tick_fall", tick_fall, m_fall);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("cfg_err",   cfg_err,   m_err);
    chk("active",    active,    m_run);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 1);
  endtask

  task automatic run_until_high();
    for (int i = 0; i < 40 && !(m_run && m_pos >= m_half); i++) cyc(1, 0, 0, 1);
  endtask

  initial begin
    bit acc_now;
    en = 0; cfg_valid = 0; cfg_half = '0; rst = 0;

    // Reset and default divide-by-4.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    run_n(12);

    // Live reconfiguration to half 5 in the middle of a high phase.
    run_until_high();
    cyc(1, 1, 5, 1);
    run_n(25);

    // Zero half-period is rejected.
    cyc(1, 1, 0, 1);
    run_n(12);

    // Stop during high phase: completes, then idles.
    run_until_high();
    for (int i = 0; i < 30 && m_run; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // Stop during low phase: immediate, no tick.
    run_n(2);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Divide-by-2, then a second offer held off while pending.
    run_n(3);
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 40; i++) begin
      acc_now = !m_pend;
      cyc(1, 1, 3, 1);
      if (acc_now) break;
    end
    run_n(14);

    // Reset while a half of 7 is pending.
    run_until_high();
    cyc(1, 1, 7, 1);
    cyc(1, 0, 0, 0);
    run_n(14);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 6)), ($urandom_range(0, 99) != 0));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
